// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and opcode-class helper
// shared by alu_seq and alu_muldiv_iter.
`timescale 1ns/1ps
package alu_pkg;

  localparam int OPCODE_LENGTH = 5;

  typedef enum logic [OPCODE_LENGTH-1:0] {
    OP_AND  = 5'b00000,
    OP_OR   = 5'b00001,
    OP_ADD  = 5'b00010,
    OP_XOR  = 5'b00011,
    OP_SLL  = 5'b00100,
    OP_SRL  = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SRA  = 5'b00111,
    OP_EQ   = 5'b01000,
    OP_NE   = 5'b01001,
    OP_GE   = 5'b01010,
    OP_LT   = 5'b01011,
    OP_SLT  = 5'b01100,
    OP_SLTU = 5'b01101,
    OP_GEU  = 5'b01110,
    OP_LTU  = 5'b01111,
    OP_MUL  = 5'b10000,
    OP_MULH = 5'b10001,
    OP_DIV  = 5'b10100,
    OP_DIVU = 5'b10101,
    OP_REM  = 5'b10110,
    OP_REMU = 5'b10111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } alu_state_e;

  function automatic logic is_iterative(
    input logic [OPCODE_LENGTH-1:0] op
  );
    return op inside {OP_MUL, OP_MULH, OP_DIV,
                      OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: unsigned shift-add multiply / restoring divide, one bit per edge.
// Ports: start/abort/is_div/a/b in; step counter, hi (prod hi / rem), lo (prod lo / quot) out.
`timescale 1ns/1ps
module alu_muldiv_iter #(
  parameter  int W  = 32,
  localparam int SW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          is_div,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [SW-1:0] step,
  output logic [W-1:0]  hi,
  output logic [W-1:0]  lo
);

  logic [W-1:0] opb;
  logic         div_q;
  logic [W:0]   msum;
  logic [W:0]   rsh;
  logic [W:0]   rtry;
  logic         fits;

  assign msum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
  assign rsh  = {hi, lo[W-1]};
  assign rtry = rsh - {1'b0, opb};
  assign fits = (rsh >= {1'b0, opb});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step  <= '0;
      hi    <= '0;
      lo    <= '0;
      opb   <= '0;
      div_q <= 1'b0;
    end else if (abort) begin
      step <= '0;
    end else if (start) begin
      step  <= SW'(W);
      hi    <= '0;
      lo    <= a;
      opb   <= b;
      div_q <= is_div;
    end else if (step != '0) begin
      step <= step - 1'b1;
      if (div_q) begin
        hi <= fits ? rtry[W-1:0] : rsh[W-1:0];
        lo <= {lo[W-2:0], fits};
      end else begin
        {hi, lo} <= {msum, lo[W-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; simple ops in 1 cycle, mul/div iterative when ALU_MULDIV_EN.
// Ports: clk, reset, flush, in_valid/in_ready, SrcA, SrcB, Operation, out_valid, ALUResult, Zero.
`timescale 1ns/1ps
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5,
  parameter int SHAMT_W       = $clog2(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  localparam int W = DATA_WIDTH;

  alu_op_e            op;
  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [W-1:0]       simple_res;
  logic               wr_en;
  logic [W-1:0]       wr_data;

  assign op     = alu_op_e'(Operation);
  assign accept = in_valid && in_ready && !flush;
  assign shamt  = SrcB[SHAMT_W-1:0];

  always_comb begin
    simple_res = '0;
    case (op)
      OP_AND:  simple_res = SrcA & SrcB;
      OP_OR:   simple_res = SrcA | SrcB;
      OP_ADD:  simple_res = SrcA + SrcB;
      OP_SUB:  simple_res = SrcA - SrcB;
      OP_XOR:  simple_res = SrcA ^ SrcB;
      OP_SLL:  simple_res = SrcA << shamt;
      OP_SRL:  simple_res = SrcA >> shamt;
      OP_SRA:  simple_res = $unsigned($signed(SrcA) >>> shamt);
      OP_EQ:   simple_res[0] = (SrcA == SrcB);
      OP_NE:   simple_res[0] = (SrcA != SrcB);
      OP_GE:   simple_res[0] = ($signed(SrcA) >= $signed(SrcB));
      OP_LT,
      OP_SLT:  simple_res[0] = ($signed(SrcA) < $signed(SrcB));
      OP_SLTU,
      OP_LTU:  simple_res[0] = (SrcA < SrcB);
      OP_GEU:  simple_res[0] = (SrcA >= SrcB);
      default: simple_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int SW = $clog2(W) + 1;

  alu_state_e   state, state_nx;
  logic         iter_start;
  logic         sgn_op, neg_a, neg_b;
  logic [W-1:0] mag_a, mag_b;
  logic [SW-1:0] step;
  logic [W-1:0] hi, lo;
  logic [W-1:0] fix_res;
  alu_op_e      op_q;
  logic         neg_q, neg_r_q, dz_q;
  logic [2*W-1:0] prod_neg;

  assign in_ready   = (state == IDLE);
  assign iter_start = accept && is_iterative(Operation);
  assign sgn_op     = op inside {OP_MULH, OP_DIV, OP_REM};
  assign neg_a      = sgn_op && SrcA[W-1];
  assign neg_b      = sgn_op && SrcB[W-1];
  assign mag_a      = neg_a ? -SrcA : SrcA;
  assign mag_b      = neg_b ? -SrcB : SrcB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (iter_start) state_nx = ITER;
      ITER: begin
        if (flush)             state_nx = IDLE;
        else if (step == SW'(1)) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result signs are captured up front; REM follows the dividend.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_AND;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (iter_start) begin
      op_q    <= op;
      neg_q   <= neg_a ^ neg_b;
      neg_r_q <= neg_a;
      dz_q    <= (SrcB == '0);
    end
  end

  alu_muldiv_iter #(.W(W)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (iter_start),
    .abort  (flush),
    .is_div (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}),
    .a      (mag_a),
    .b      (mag_b),
    .step   (step),
    .hi     (hi),
    .lo     (lo)
  );

  assign prod_neg = -{hi, lo};

  always_comb begin
    fix_res = neg_r_q ? -hi : hi;
    case (op_q)
      OP_MUL:  fix_res = lo;
      OP_MULH: fix_res = neg_q ? prod_neg[2*W-1:W] : hi;
      OP_DIV,
      OP_DIVU: fix_res = dz_q ? '1 : (neg_q ? -lo : lo);
      default: fix_res = neg_r_q ? -hi : hi;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = simple_res;
    if (accept && !is_iterative(Operation)) begin
      wr_en = 1'b1;
    end else if (state == FIX && !flush) begin
      wr_en   = 1'b1;
      wr_data = fix_res;
    end
  end
`else
  assign in_ready = 1'b1;
  assign wr_en    = accept;
  assign wr_data  = simple_res;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResult <= '0;
      Zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= wr_en;
      if (wr_en) begin
        ALUResult <= wr_data;
        Zero      <= (wr_data == '0);
      end
    end
  end

endmodule
